mul_req_master: RTL and testbench
=================================

Name: mul_req_master

Overview:
- Initiator side of the req/ack signed-multiplier interface used by vdic_dut_2023.
- Accepts operand pairs from an upstream valid/ready stream, generates argument parity, and drives req/ack to the multiplier.
- Captures result, result_parity and arg_parity_error, checks result parity, and returns result plus status on a downstream valid/ready stream.
- Optional parity-error injection; timeout watchdog.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in REQ without ack before abort; 0 disables timeout
CNT_W, 16, width of transaction/error counters

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
in_valid  in  1  upstream operand pair valid
in_ready  out  1  upstream ready; equals (state==IDLE)
in_a  in  16  signed operand A
in_b  in  16  signed operand B
in_inject  in  2  bit0 invert arg_a_parity, bit1 invert arg_b_parity
arg_a  out  16  to multiplier
arg_a_parity  out  1  ^arg_a, optionally inverted
arg_b  out  16  to multiplier
arg_b_parity  out  1  ^arg_b, optionally inverted
req  out  1  request to multiplier
ack  in  1  multiplier acknowledge; result valid when high
result  in  32  signed product
result_parity  in  1  multiplier result parity
arg_parity_error  in  1  multiplier detected bad argument parity
out_valid  out  1  downstream result valid
out_ready  in  1  downstream ready
out_result  out  32  captured product
out_status  out  3  {timeout, result_parity_err, arg_parity_err}
txn_count  out  CNT_W  completed transactions, saturating
err_count  out  CNT_W  transactions with any status bit set, saturating

Behaviour:
- Reset (rst_n=0 sampled on posedge): state=IDLE; req=0; arg_a/arg_b/parities=0; out_valid=0; out_result=0; out_status=0; counters=0; timer=0. Reset applies mid-transaction: req is low after that edge and nothing is emitted.
- FSM states: IDLE, REQ, DONE, DRAIN.
- IDLE: in_ready=1. On in_valid at edge N: register arg_a=in_a, arg_b=in_b, arg_x_parity=^arg_x XOR in_inject[x]; req=1 after edge N; timer=0; go REQ.
- REQ: req=1; arg_* and parities held stable.
  - ack=1 at an edge: capture out_result=result and arg_parity_err=arg_parity_error.
  - result_parity_err = (result_parity != ^result) AND NOT arg_parity_error. Result parity is not checked when arg_parity_error=1.
  - After that edge: req=0, out_valid=1; go DONE.
  - Else timer++. If TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES-1 without ack: after that edge req=0, out_result=0, out_status=3'b100, out_valid=1; go DONE. Net effect: req is high for exactly TIMEOUT_CYCLES cycles.
- Minimum latency: ack at edge N+1 gives out_valid high after N+1.
- DONE: out_valid=1 and output held stable until out_valid&&out_ready.
  - On that edge: out_valid=0; txn_count++; err_count++ if out_status!=0.
  - Next state: IDLE if ack==0 at that edge, else DRAIN.
- DRAIN: wait for ack==0, then IDLE. Guards against a multi-cycle ack being counted twice; no new req while ack is high.
- ack while not in REQ: ignored.
- Counters saturate at all-ones.
- No new operand is accepted until the previous output is consumed (single outstanding transaction).

Test Plan:
1. in_a=3, in_b=-2; model acks 2 cycles after req with result=0xFFFFFFFA and correct parity -> req high exactly 2 cycles, arg_a_parity=0, arg_b_parity=1, out_result=0xFFFFFFFA, out_status=000, txn_count=1.
2. in_a=16'sh8000, in_b=16'sh8000 -> out_result=0x40000000, status 000. Also 0x7FFF*0x7FFF -> 0x3FFF0001.
3. in_inject=2'b01, in_a=0x0001 -> arg_a_parity=0; model returns arg_parity_error=1, result_parity wrong -> out_status=001, err_count=1.
4. Model returns result=5, result_parity=1 -> out_status=010; out_result=5.
5. TIMEOUT_CYCLES=8, ack tied 0 -> req high 8 cycles then low, out_result=0, out_status=100; a later ack is ignored.
6. out_ready=0 for 5 cycles and ack held high 3 cycles -> one output only, in_ready=0 until ack low. Separately, rst_n=0 mid-REQ -> req=0 and out_valid=0 after that edge, counters=0.

Source files
------------

// File: rtl/mul_req_master.sv
// mul_req_master
// Initiator for the req/ack signed-multiplier interface. It takes one operand
// pair at a time from an upstream valid/ready stream and attaches argument
// parity, with optional per-operand parity inversion for fault injection. It
// holds req until ack or until the watchdog expires, then returns the product
// and a status word on a downstream valid/ready stream.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   in_valid/in_ready           upstream handshake (ready only when idle)
//   in_a, in_b                  signed operands
//   in_inject                   bit0/bit1 invert arg_a/arg_b parity
//   arg_a(_parity), arg_b(_parity), req   to multiplier
//   ack, result, result_parity, arg_parity_error   from multiplier
//   out_valid/out_ready         downstream handshake
//   out_result                  captured signed product (0 on timeout)
//   out_status                  {timeout, result_parity_err, arg_parity_err}
//   txn_count, err_count        saturating completed / errored transaction counts
module mul_req_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_a,
    input  logic signed [15:0]      in_b,
    input  logic        [1:0]       in_inject,
    output logic signed [15:0]      arg_a,
    output logic                    arg_a_parity,
    output logic signed [15:0]      arg_b,
    output logic                    arg_b_parity,
    output logic                    req,
    input  logic                    ack,
    input  logic signed [31:0]      result,
    input  logic                    result_parity,
    input  logic                    arg_parity_error,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [31:0]      out_result,
    output logic        [2:0]       out_status,
    output logic        [CNT_W-1:0] txn_count,
    output logic        [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

    // Timer only has to reach TIMEOUT_CYCLES-1.
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic             timeout_hit;

    function automatic logic parity16(input logic signed [15:0] v);
        return ^v;
    endfunction

    function automatic logic parity32(input logic signed [31:0] v);
        return ^v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Ack in the same cycle as expiry wins: the real result is kept.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)              state_nxt = REQ;
            REQ:     if (ack || timeout_hit)    state_nxt = DONE;
            // A still-high ack at hand-off must drop before the next request,
            // otherwise the same ack would complete the following transaction.
            DONE:    if (out_ready)             state_nxt = ack ? DRAIN : IDLE;
            DRAIN:   if (!ack)                  state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE);
        req       = (state == REQ);
        out_valid = (state == DONE);
    end

    // Operand, result, timer and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arg_a        <= '0;
            arg_b        <= '0;
            arg_a_parity <= 1'b0;
            arg_b_parity <= 1'b0;
            out_result   <= '0;
            out_status   <= '0;
            timer        <= '0;
            txn_count    <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        arg_a        <= in_a;
                        arg_b        <= in_b;
                        arg_a_parity <= parity16(in_a) ^ in_inject[0];
                        arg_b_parity <= parity16(in_b) ^ in_inject[1];
                        timer        <= '0;
                    end
                end
                REQ: begin
                    if (ack) begin
                        out_result <= result;
                        // A rejected argument makes the result parity meaningless.
                        out_status <= {1'b0,
                                       (result_parity != parity32(result)) && !arg_parity_error,
                                       arg_parity_error};
                    end else if (timeout_hit) begin
                        out_result <= '0;
                        out_status <= 3'b100;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        txn_count <= sat_inc(txn_count);
                        if (out_status != 3'b000) begin
                            err_count <= sat_inc(err_count);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_req_master.sv
// Directed bench for mul_req_master with TIMEOUT_CYCLES=8: a vector table of
// single transactions against a behavioural multiplier responder, followed by
// hand-written sequences for output back-pressure, long ack, and mid-request reset.
module tb_mul_req_master;

    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_a, in_b;
    logic [1:0]         in_inject;
    logic signed [15:0] arg_a, arg_b;
    logic               arg_a_parity, arg_b_parity;
    logic               req;
    logic               ack;
    logic signed [31:0] result;
    logic               result_parity;
    logic               arg_parity_error;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_result;
    logic [2:0]         out_status;
    logic [CNT_W-1:0]   txn_count, err_count;

    int total = 0;
    int bad   = 0;
    int exp_txn = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    mul_req_master #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_inject(in_inject),
        .arg_a(arg_a), .arg_a_parity(arg_a_parity),
        .arg_b(arg_b), .arg_b_parity(arg_b_parity),
        .req(req), .ack(ack),
        .result(result), .result_parity(result_parity),
        .arg_parity_error(arg_parity_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_status(out_status),
        .txn_count(txn_count), .err_count(err_count)
    );

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [1:0]         inj;
        int                 d;        // req cycles before ack; 0 = never ack
        logic [31:0]        res;
        logic               rp;
        logic               ape;
        logic               pa;
        logic               pb;
        int                 req_cyc;
        logic [31:0]        exp_res;
        logic [2:0]         exp_st;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic counts_chk(input string tag);
        chk({tag, "_txn"}, 32'(txn_count), 32'(exp_txn));
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
    endtask

    // Present one operand pair; returns with the DUT in REQ, at a negedge.
    task automatic issue(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic [1:0] inj);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_inject = inj;
        @(negedge clk);
        in_valid  = 1'b0;
        in_inject = 2'b00;
        chk("req_rise", 32'(req), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int  cnt;
        bit  done;
        issue(v.a, v.b, v.inj);
        chk("arg_a", 32'(arg_a), 32'(v.a));
        chk("arg_b", 32'(arg_b), 32'(v.b));
        chk("arg_a_parity", 32'(arg_a_parity), 32'(v.pa));
        chk("arg_b_parity", 32'(arg_b_parity), 32'(v.pb));
        cnt  = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (out_valid) begin
                ack  = 1'b0;
                done = 1;
            end else begin
                if (req) cnt++;
                if (v.d != 0 && cnt == v.d) begin
                    ack              = 1'b1;
                    result           = v.res;
                    result_parity    = v.rp;
                    arg_parity_error = v.ape;
                end
                @(negedge clk);
            end
        end
        ack = 1'b0;
        chk("out_valid_within_bound", 32'(done), 32'd1);
        chk("req_cycles", 32'(cnt), 32'(v.req_cyc));
        chk("out_result", out_result, v.exp_res);
        chk("out_status", 32'(out_status), 32'(v.exp_st));
        // out_ready is high: consumed on the next edge.
        @(negedge clk);
        arg_parity_error = 1'b0;
        exp_txn++;
        if (v.exp_st != 3'b000) exp_err++;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        counts_chk("vec");
    endtask

    initial begin
        logic signed [31:0] held;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_inject = '0;
        ack = 1'b0; result = '0; result_parity = 1'b0; arg_parity_error = 1'b0;
        out_ready = 1'b1;

        //          a          b          inj    d  res           rp    ape   pa    pb   rc exp_res       st
        vecs[0] = '{16'sd3,     -16'sd2,   2'b00, 2, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, 1'b1, 2, 32'hFFFFFFFA, 3'b000};
        vecs[1] = '{16'sh8000,  16'sh8000, 2'b00, 1, 32'h40000000, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h40000000, 3'b000};
        vecs[2] = '{16'sh7FFF,  16'sh7FFF, 2'b00, 3, 32'h3FFF0001, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h3FFF0001, 3'b000};
        vecs[3] = '{16'sd1,     16'sd2,    2'b01, 1, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b1, 1, 32'h00000002, 3'b001};
        vecs[4] = '{16'sd5,     16'sd1,    2'b00, 2, 32'h00000005, 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h00000005, 3'b010};
        vecs[5] = '{-16'sd100,  16'sd300,  2'b10, 4, 32'hFFFF8AD0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'hFFFF8AD0, 3'b000};
        vecs[6] = '{16'sd7,     16'sd7,    2'b00, 0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 8, 32'h00000000, 3'b100};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_arg_a", 32'(arg_a), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_status", 32'(out_status), 32'd0);
        counts_chk("rst");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Ack outside REQ is ignored.
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("stray_ack_req", 32'(req), 32'd0);
        chk("stray_ack_out_valid", 32'(out_valid), 32'd0);
        chk("stray_ack_in_ready", 32'(in_ready), 32'd1);
        counts_chk("stray_ack");

        // Back-pressure: output held for 5 cycles with out_ready low.
        out_ready = 1'b0;
        issue(16'sd2, 16'sd3, 2'b00);
        ack = 1'b1; result = 32'sd6; result_parity = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        held = out_result;
        chk("bp_result", out_result, 32'd6);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_result_hold", out_result, held);
            @(negedge clk);
        end
        counts_chk("bp_pending");
        out_ready = 1'b1;
        @(negedge clk);
        exp_txn++;
        chk("bp_out_valid_drop", 32'(out_valid), 32'd0);
        counts_chk("bp_done");

        // Ack high for 3 edges spanning the hand-off: one output, then drain.
        issue(-16'sd4, 16'sd4, 2'b00);
        ack = 1'b1; result = -32'sd16; result_parity = 1'b0;   // 0xFFFFFFF0: 28 ones
        @(negedge clk);                                         // edge 1: REQ -> DONE
        chk("la_out_valid", 32'(out_valid), 32'd1);
        chk("la_result", out_result, 32'hFFFFFFF0);
        chk("la_status", 32'(out_status), 32'd0);
        @(negedge clk);                                         // edge 2: consumed, DRAIN
        exp_txn++;
        chk("la_out_valid_drop", 32'(out_valid), 32'd0);
        chk("la_in_ready_drain", 32'(in_ready), 32'd0);
        counts_chk("la_consumed");
        @(negedge clk);                                         // edge 3: ack still high
        ack = 1'b0;
        chk("la_still_drain", 32'(in_ready), 32'd0);
        chk("la_no_req", 32'(req), 32'd0);
        chk("la_no_second_out", 32'(out_valid), 32'd0);
        @(negedge clk);                                         // edge 4: back to IDLE
        chk("la_idle", 32'(in_ready), 32'd1);
        counts_chk("la_final");

        // Reset in the middle of a request.
        issue(16'sd9, 16'sd9, 2'b00);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_txn = 0;
        exp_err = 0;
        chk("mrst_req", 32'(req), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_arg_a", 32'(arg_a), 32'd0);
        counts_chk("mrst");
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_emit", 32'(out_valid), 32'd0);
        end

        // A transaction after reset still works and counts from zero.
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
